vend_controller: RTL and testbench

- Top-level sequencer for the candy vending machine: accepts Rs1/Rs2 coins over a valid/ready handshake and accumulates credit.
- When credit reaches PRICE, it requests one candy from the dispenser, then returns change one Rs1 unit at a time.
- Cancel or an inactivity timeout refunds the full credit.
- Sits between the coin slot front-end and the dispenser/return-chute actuators, which acknowledge each request.

---
 rtl/vend_pkg.sv | 22 ++
 rtl/vend_if.sv | 22 ++
 rtl/vend_timeout_timer.sv | 28 ++
 rtl/vend_controller.sv | 152 +++++++++++++++
 tb/tb_vend_controller.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared encodings for the candy vending controller: state codes, coin codes
// and the credit width.
package vend_pkg;

    localparam int CW = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_CHANGE   = 3'd3,
        ST_REFUND   = 3'd4
    } state_t;

    localparam logic COIN_RS1 = 1'b0;
    localparam logic COIN_RS2 = 1'b1;

    function automatic logic [CW-1:0] coin_value(input logic coin_type);
        return (coin_type == COIN_RS2) ? CW'(2) : CW'(1);
    endfunction

endpackage

// File: rtl/vend_if.sv
// Handshake bundle between the vending controller, the coin slot front-end
// and the dispenser / return-chute actuators.
interface vend_if;
    logic coin_valid;
    logic coin_type;
    logic coin_ready;
    logic cancel;
    logic candy_req;
    logic candy_ack;
    logic ret_req;
    logic ret_ack;

    modport slave (
        input  coin_valid, coin_type, cancel, candy_ack, ret_ack,
        output coin_ready, candy_req, ret_req
    );

    modport master (
        output coin_valid, coin_type, cancel, candy_ack, ret_ack,
        input  coin_ready, candy_req, ret_req
    );
endinterface

// File: rtl/vend_timeout_timer.sv
// Inactivity timer for the coin-collect phase; expire is high while the
// count sits at TIMEOUT-1.
module vend_timeout_timer #(
    parameter int TIMEOUT = 1000,
    parameter int TW      = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TW'(1);
        end
    end

    assign expire = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/vend_controller.sv
// Candy vending sequencer: collects coins, dispenses one candy at PRICE,
// then returns change or refunds credit one Rs1 coin at a time.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | no credit, waiting for the first coin
// ST_COLLECT  | partial credit held, inactivity timer running
// ST_DISPENSE | candy_req held until the dispenser acknowledges
// ST_CHANGE   | returning overpayment, one ret_req pulse per coin
// ST_REFUND   | returning full credit after cancel or timeout
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE   = 2,
    parameter int TIMEOUT = 1000,
    parameter int TW      = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    vend_if.slave         bus,
    output logic [CW-1:0] credit,
    output logic          busy,
    output logic [7:0]    sales_count
);

    localparam logic [CW-1:0] PRICE_C = CW'(PRICE);

    state_t        state, state_nxt;
    logic [CW-1:0] credit_nxt;
    logic [CW-1:0] change, change_nxt;
    logic [CW-1:0] sum;
    logic [7:0]    sales_nxt;
    logic          candy_req, candy_req_nxt;
    logic          ret_req, ret_req_nxt;
    logic          busy_nxt;
    logic          coin_ready;
    logic          accept;
    logic          candy_done;
    logic          ret_done;
    logic          timer_en;
    logic          timer_clear;
    logic          expire;

    assign coin_ready     = (state == ST_IDLE) || (state == ST_COLLECT);
    assign bus.coin_ready = coin_ready;
    assign bus.candy_req  = candy_req;
    assign bus.ret_req    = ret_req;

    assign accept     = bus.coin_valid && coin_ready;
    assign sum        = credit + coin_value(bus.coin_type);
    assign candy_done = candy_req && bus.candy_ack;
    assign ret_done   = ret_req && bus.ret_ack;

    // Timer idles at zero outside COLLECT, so every entry starts fresh.
    assign timer_en    = (state == ST_COLLECT);
    assign timer_clear = !timer_en || accept;

    vend_timeout_timer #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .enable (timer_en),
        .expire (expire)
    );

    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        change_nxt = change;
        sales_nxt  = sales_count;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    credit_nxt = sum;
                    if (sum >= PRICE_C) begin
                        change_nxt = sum - PRICE_C;
                        state_nxt  = ST_DISPENSE;
                    end else begin
                        state_nxt = ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                // Cancel wins over a simultaneous coin, which joins the refund.
                if (bus.cancel) begin
                    if (accept) credit_nxt = sum;
                    state_nxt = ST_REFUND;
                end else if (accept) begin
                    credit_nxt = sum;
                    if (sum >= PRICE_C) begin
                        change_nxt = sum - PRICE_C;
                        state_nxt  = ST_DISPENSE;
                    end
                end else if (expire) begin
                    state_nxt = ST_REFUND;
                end
            end
            ST_DISPENSE: begin
                if (candy_done) begin
                    credit_nxt = change;
                    change_nxt = '0;
                    sales_nxt  = sales_count + 8'd1;
                    state_nxt  = (change != '0) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE, ST_REFUND: begin
                if (credit == '0) begin
                    state_nxt = ST_IDLE;
                end else if (ret_done) begin
                    credit_nxt = credit - CW'(1);
                    if (credit == CW'(1)) state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                credit_nxt = '0;
                change_nxt = '0;
            end
        endcase

        candy_req_nxt = (state_nxt == ST_DISPENSE);
        // Dropping ret_req after each ack forces a one-cycle gap per coin.
        ret_req_nxt   = ((state_nxt == ST_CHANGE) || (state_nxt == ST_REFUND)) && !ret_done;
        busy_nxt      = (state_nxt == ST_DISPENSE) || (state_nxt == ST_CHANGE) ||
                        (state_nxt == ST_REFUND);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            credit      <= '0;
            change      <= '0;
            sales_count <= '0;
            candy_req   <= 1'b0;
            ret_req     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            credit      <= credit_nxt;
            change      <= change_nxt;
            sales_count <= sales_nxt;
            candy_req   <= candy_req_nxt;
            ret_req     <= ret_req_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: two instances (PRICE=2/TIMEOUT=5 and
// PRICE=3) with a scoreboard of expected purchase outcomes.
module tb_vend_controller;
    import vend_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    vend_if ia ();
    vend_if ib ();

    logic [CW-1:0] credit_a, credit_b;
    logic          busy_a, busy_b;
    logic [7:0]    sales_a, sales_b;

    vend_controller #(.PRICE(2), .TIMEOUT(5), .TW(4)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (ia.slave),
        .credit      (credit_a),
        .busy        (busy_a),
        .sales_count (sales_a)
    );

    vend_controller #(.PRICE(3), .TIMEOUT(1000), .TW(10)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (ib.slave),
        .credit      (credit_b),
        .busy        (busy_b),
        .sales_count (sales_b)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string tag;
        int    credit;
        int    sales;
        int    rets;
    } exp_t;
    exp_t sb[$];

    int   obs_credit_a;
    int   ret_rise_a   = 0;
    logic ret_prev_a   = 1'b0;
    int   candy_rise_b = 0;
    logic candy_prev_b = 1'b0;

    always @(negedge clk) begin
        if (ia.ret_req === 1'b1 && ret_prev_a !== 1'b1) ret_rise_a <= ret_rise_a + 1;
        ret_prev_a <= ia.ret_req;
        if (ib.candy_req === 1'b1 && candy_prev_b !== 1'b1) candy_rise_b <= candy_rise_b + 1;
        candy_prev_b <= ib.candy_req;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin_a(input logic t);
        ia.coin_valid = 1'b1;
        ia.coin_type  = t;
        tick();
        ia.coin_valid = 1'b0;
    endtask

    task automatic serve_candy_a();
        int w = 0;
        while (ia.candy_req !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        check("candy_req_wait", ia.candy_req, 1);
        obs_credit_a = int'(credit_a);
        if (ia.candy_req === 1'b1) begin
            ia.candy_ack = 1'b1;
            tick();
            ia.candy_ack = 1'b0;
        end
    endtask

    task automatic serve_returns_a(output int n);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (busy_a !== 1'b1) break;
            if (ia.ret_req === 1'b1) begin
                ia.ret_ack = 1'b1;
                tick();
                ia.ret_ack = 1'b0;
                n++;
            end else begin
                tick();
            end
        end
        check("returns_done", busy_a, 0);
    endtask

    task automatic sb_check_a(input int rets);
        exp_t e;
        check("sb_size", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "_credit"}, obs_credit_a, e.credit);
            check({e.tag, "_sales"}, sales_a, e.sales);
            check({e.tag, "_rets"}, rets, e.rets);
            check({e.tag, "_credit_end"}, credit_a, 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rise0;

        rst_n = 1'b0;
        ia.coin_valid = 0; ia.coin_type = 0; ia.cancel = 0; ia.candy_ack = 0; ia.ret_ack = 0;
        ib.coin_valid = 0; ib.coin_type = 0; ib.cancel = 0; ib.candy_ack = 0; ib.ret_ack = 0;
        tick();
        tick();
        check("rst_credit", credit_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_sales", sales_a, 0);
        check("rst_candy_req", ia.candy_req, 0);
        check("rst_ret_req", ia.ret_req, 0);
        check("rst_coin_ready", ia.coin_ready, 1);
        rst_n = 1'b1;
        tick();

        // Exact payment
        rise0 = ret_rise_a;
        sb.push_back('{"exact", 2, 1, 0});
        coin_a(COIN_RS2);
        check("exact_disp_credit", credit_a, 2);
        check("exact_candy_req", ia.candy_req, 1);
        check("exact_busy", busy_a, 1);
        check("exact_coin_ready", ia.coin_ready, 0);
        serve_candy_a();
        check("exact_candy_drop", ia.candy_req, 0);
        serve_returns_a(n);
        tick();
        check("exact_no_ret", ret_rise_a - rise0, 0);
        sb_check_a(n);

        // Acks with no request pending must be ignored
        ia.candy_ack = 1'b1;
        ia.ret_ack   = 1'b1;
        tick();
        ia.candy_ack = 1'b0;
        ia.ret_ack   = 1'b0;
        check("stray_ack_sales", sales_a, 1);
        check("stray_ack_busy", busy_a, 0);

        // Overpayment: Rs1 then Rs2
        rise0 = ret_rise_a;
        sb.push_back('{"overpay", 3, 2, 1});
        coin_a(COIN_RS1);
        check("overpay_collect_credit", credit_a, 1);
        check("overpay_collect_busy", busy_a, 0);
        coin_a(COIN_RS2);
        serve_candy_a();
        check("overpay_change_credit", credit_a, 1);
        check("overpay_change_ret_req", ia.ret_req, 1);
        serve_returns_a(n);
        tick();
        check("overpay_ret_pulses", ret_rise_a - rise0, 1);
        sb_check_a(n);

        // Backpressure during DISPENSE
        sb.push_back('{"backpressure", 2, 3, 0});
        coin_a(COIN_RS2);
        ia.coin_valid = 1'b1;
        ia.coin_type  = COIN_RS2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_coin_ready", ia.coin_ready, 0);
            check("bp_credit", credit_a, 2);
        end
        ia.coin_valid = 1'b0;
        serve_candy_a();
        serve_returns_a(n);
        sb_check_a(n);

        // Timeout: REFUND exactly 5 cycles after the accept edge
        coin_a(COIN_RS1);
        for (int i = 1; i < 5; i++) tick();
        check("timeout_before_busy", busy_a, 0);
        check("timeout_before_ready", ia.coin_ready, 1);
        tick();
        check("timeout_busy", busy_a, 1);
        check("timeout_ret_req", ia.ret_req, 1);
        check("timeout_credit", credit_a, 1);
        serve_returns_a(n);
        check("timeout_rets", n, 1);
        check("timeout_sales", sales_a, 3);

        // Reset in the middle of a refund holding credit 2
        coin_a(COIN_RS1);
        ia.coin_valid = 1'b1;
        ia.coin_type  = COIN_RS1;
        ia.cancel     = 1'b1;
        tick();
        ia.coin_valid = 1'b0;
        ia.cancel     = 1'b0;
        check("midrst_refund_credit", credit_a, 2);
        check("midrst_refund_ret_req", ia.ret_req, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_credit", credit_a, 0);
        check("midrst_busy", busy_a, 0);
        check("midrst_ret_req", ia.ret_req, 0);
        check("midrst_candy_req", ia.candy_req, 0);
        check("midrst_sales", sales_a, 0);
        check("midrst_coin_ready", ia.coin_ready, 1);
        tick();

        // 256 purchases wrap sales_count
        for (int i = 0; i < 256; i++) begin
            sb.push_back('{"wrap", 2, (i + 1) % 256, 0});
            coin_a(COIN_RS2);
            serve_candy_a();
            serve_returns_a(n);
            sb_check_a(n);
        end
        check("wrap_final_sales", sales_a, 0);

        // PRICE=3 instance: cancel in IDLE is ignored
        ib.cancel = 1'b1;
        tick();
        tick();
        ib.cancel = 1'b0;
        check("b_idle_cancel_busy", busy_b, 0);
        check("b_idle_cancel_ready", ib.coin_ready, 1);

        // Cancel colliding with an Rs2 coin
        ib.coin_valid = 1'b1;
        ib.coin_type  = COIN_RS1;
        tick();
        check("b_collect_credit", credit_b, 1);
        ib.coin_type  = COIN_RS2;
        ib.cancel     = 1'b1;
        tick();
        ib.coin_valid = 1'b0;
        ib.cancel     = 1'b0;
        check("b_refund_credit", credit_b, 3);
        check("b_refund_busy", busy_b, 1);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (busy_b !== 1'b1) break;
            if (ib.ret_req === 1'b1) begin
                ib.ret_ack = 1'b1;
                tick();
                ib.ret_ack = 1'b0;
                n++;
            end else begin
                tick();
            end
        end
        tick();
        check("b_refund_pulses", n, 3);
        check("b_refund_done", busy_b, 0);
        check("b_refund_credit_end", credit_b, 0);
        check("b_no_candy", candy_rise_b, 0);
        check("b_sales", sales_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
